// File: rtl/usr_pkg.sv
// Shared mode encoding for the universal shift register and the controllers that drive it.
package usr_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_LOAD = 3'b001;
  localparam mode_t MODE_SHL  = 3'b010;
  localparam mode_t MODE_SHR  = 3'b011;
  localparam mode_t MODE_ROL  = 3'b100;
  localparam mode_t MODE_ROR  = 3'b101;
  localparam mode_t MODE_ASR  = 3'b110;
  localparam mode_t MODE_CLR  = 3'b111;

endpackage

// File: rtl/usr_next_val.sv
// Combinational next-state function: the next register value and the counter action
// implied by the selected mode.
module usr_next_val
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  mode_t            mode,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q_next,
  output logic             cnt_inc,
  output logic             cnt_clr
);

  logic [WIDTH-1:0] shl_v;
  logic [WIDTH-1:0] shr_v;
  logic [WIDTH-1:0] rol_v;
  logic [WIDTH-1:0] ror_v;
  logic [WIDTH-1:0] asr_v;

  // A one-bit register has no neighbours: shifts take the serial input, rotates keep q.
  generate
    if (WIDTH == 1) begin : g_w1
      assign shl_v = sin_r;
      assign shr_v = sin_l;
      assign rol_v = q;
      assign ror_v = q;
      assign asr_v = q;
    end else begin : g_wn
      assign shl_v = {q[WIDTH-2:0], sin_r};
      assign shr_v = {sin_l, q[WIDTH-1:1]};
      assign rol_v = {q[WIDTH-2:0], q[WIDTH-1]};
      assign ror_v = {q[0], q[WIDTH-1:1]};
      assign asr_v = {q[WIDTH-1], q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    q_next  = q;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    case (mode)
      MODE_HOLD: q_next = q;
      MODE_LOAD: begin q_next = d;     cnt_clr = 1'b1; end
      MODE_SHL:  begin q_next = shl_v; cnt_inc = 1'b1; end
      MODE_SHR:  begin q_next = shr_v; cnt_inc = 1'b1; end
      MODE_ROL:  begin q_next = rol_v; cnt_inc = 1'b1; end
      MODE_ROR:  begin q_next = ror_v; cnt_inc = 1'b1; end
      MODE_ASR:  begin q_next = asr_v; cnt_inc = 1'b1; end
      MODE_CLR:  begin q_next = '0;    cnt_clr = 1'b1; end
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register with clock enable, eight modes and a saturating
// count of shift/rotate operations since the last load or clear.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             zero,
  output logic [CNT_W-1:0] shift_cnt
);

  logic [WIDTH-1:0] q_next;
  logic             cnt_inc;
  logic             cnt_clr;

  usr_next_val #(.WIDTH(WIDTH)) u_next (
    .q       (q),
    .d       (d),
    .mode    (mode),
    .sin_l   (sin_l),
    .sin_r   (sin_r),
    .q_next  (q_next),
    .cnt_inc (cnt_inc),
    .cnt_clr (cnt_clr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= q_next;
    end
  end

  // The counter sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_cnt <= '0;
    end else if (en) begin
      if (cnt_clr) begin
        shift_cnt <= '0;
      end else if (cnt_inc && (shift_cnt != {CNT_W{1'b1}})) begin
        shift_cnt <= shift_cnt + CNT_W'(1);
      end
    end
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];
  assign zero   = (q == '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg at WIDTH=8, CNT_W=4, RST_VAL=0.
module tb_univ_shift_reg;
  import usr_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  mode_t      mode;
  logic [7:0] d;
  logic       sin_l;
  logic       sin_r;
  logic [7:0] q;
  logic       sout_l;
  logic       sout_r;
  logic       zero;
  logic [3:0] shift_cnt;

  int vectors;
  int miscompares;

  univ_shift_reg #(.WIDTH(8), .CNT_W(4), .RST_VAL(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .d         (d),
    .sin_l     (sin_l),
    .sin_r     (sin_r),
    .q         (q),
    .sout_l    (sout_l),
    .sout_r    (sout_r),
    .zero      (zero),
    .shift_cnt (shift_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive inputs at the falling edge, then return just after the next rising edge.
  task automatic applyStimulus(input logic en_v, input mode_t mode_v, input logic [7:0] d_v,
                               input logic sin_l_v, input logic sin_r_v);
    @(negedge clk);
    en    = en_v;
    mode  = mode_v;
    d     = d_v;
    sin_l = sin_l_v;
    sin_r = sin_r_v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input logic [7:0] exp_q, input logic [3:0] exp_cnt);
    checkOutput({tag, ".q"}, 32'(q), 32'(exp_q));
    checkOutput({tag, ".cnt"}, 32'(shift_cnt), 32'(exp_cnt));
  endtask

  logic [7:0] exp_q;
  logic [3:0] exp_cnt;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    en    = 1'b0;
    mode  = MODE_HOLD;
    d     = 8'h00;
    sin_l = 1'b0;
    sin_r = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkState("reset", 8'h00, 4'd0);
    checkOutput("reset.zero", 32'(zero), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Async reset between edges
    applyStimulus(1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0);
    checkState("load_ff", 8'hFF, 4'd0);
    checkOutput("load_ff.zero", 32'(zero), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkState("async_rst", 8'h00, 4'd0);
    checkOutput("async_rst.zero", 32'(zero), 32'd1);
    @(posedge clk);
    #1;
    checkState("rst_held", 8'h00, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    // Load and shift left
    applyStimulus(1'b1, MODE_LOAD, 8'hA5, 1'b0, 1'b0);
    checkState("load_a5", 8'hA5, 4'd0);
    applyStimulus(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b1);
    checkState("shl", 8'h4B, 4'd1);
    checkOutput("shl.sout_l", 32'(sout_l), 32'd0);
    checkOutput("shl.sout_r", 32'(sout_r), 32'd1);
    applyStimulus(1'b1, MODE_HOLD, 8'hFF, 1'b1, 1'b1);
    checkState("hold", 8'h4B, 4'd1);

    // Rotates
    applyStimulus(1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0);
    checkState("load_81", 8'h81, 4'd0);
    applyStimulus(1'b1, MODE_ROR, 8'h00, 1'b1, 1'b1);
    checkState("ror1", 8'hC0, 4'd1);
    applyStimulus(1'b1, MODE_ROR, 8'h00, 1'b0, 1'b0);
    checkState("ror2", 8'h60, 4'd2);
    applyStimulus(1'b1, MODE_ROL, 8'h00, 1'b1, 1'b1);
    checkState("rol", 8'hC0, 4'd3);

    // Arithmetic and logical right shifts
    applyStimulus(1'b1, MODE_LOAD, 8'h80, 1'b0, 1'b0);
    applyStimulus(1'b1, MODE_ASR, 8'h00, 1'b0, 1'b1);
    checkState("asr1", 8'hC0, 4'd1);
    applyStimulus(1'b1, MODE_ASR, 8'h00, 1'b0, 1'b0);
    checkState("asr2", 8'hE0, 4'd2);
    applyStimulus(1'b1, MODE_ASR, 8'h00, 1'b0, 1'b0);
    checkState("asr3", 8'hF0, 4'd3);
    applyStimulus(1'b1, MODE_LOAD, 8'h80, 1'b0, 1'b0);
    applyStimulus(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b1);
    checkState("shr0", 8'h40, 4'd1);
    applyStimulus(1'b1, MODE_SHR, 8'h00, 1'b1, 1'b0);
    checkState("shr1", 8'hA0, 4'd2);

    // Build q=3C, cnt=5, then gate the enable
    applyStimulus(1'b1, MODE_LOAD, 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
    checkState("setup_3c", 8'h3C, 4'd5);
    applyStimulus(1'b0, MODE_LOAD, 8'hFF, 1'b1, 1'b1);
    checkState("en0_load", 8'h3C, 4'd5);
    applyStimulus(1'b0, MODE_CLR, 8'hFF, 1'b1, 1'b1);
    checkState("en0_clr", 8'h3C, 4'd5);
    applyStimulus(1'b0, MODE_SHL, 8'hFF, 1'b1, 1'b1);
    checkState("en0_shl", 8'h3C, 4'd5);
    applyStimulus(1'b0, MODE_LOAD, 8'hFF, 1'b1, 1'b1);
    checkState("en0_load2", 8'h3C, 4'd5);

    // Counter saturation while the single 1 shifts out
    applyStimulus(1'b1, MODE_LOAD, 8'h01, 1'b0, 1'b0);
    exp_q   = 8'h01;
    exp_cnt = 4'd0;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
      exp_q = {exp_q[6:0], 1'b0};
      if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
      checkState($sformatf("sat%0d", i), exp_q, exp_cnt);
      checkOutput($sformatf("sat%0d.zero", i), 32'(zero), 32'(exp_q == 8'h00));
    end
    applyStimulus(1'b1, MODE_CLR, 8'hFF, 1'b1, 1'b1);
    checkState("clr", 8'h00, 4'd0);
    checkOutput("clr.zero", 32'(zero), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register with enable and eight operating modes.
- Modes: hold, parallel load, logical shift left/right, rotate left/right, arithmetic shift right, synchronous clear.
- Keeps a saturating count of shift/rotate operations since the last load or clear.
- Serves as the generic storage/serialiser element for datapath and serial-link blocks.

Parameters:
WIDTH, 8, register width in bits (>=1)
CNT_W, 4, width of shift counter (>=1)
RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
en  input  1  clock enable; 0 = hold all state
mode  input  3  operation select (encoding below)
d  input  WIDTH  parallel load data
sin_l  input  1  serial input entering at MSB (SHR)
sin_r  input  1  serial input entering at LSB (SHL)
q  output  WIDTH  register contents
sout_l  output  1  q[WIDTH-1], combinational from q
sout_r  output  1  q[0], combinational from q
zero  output  1  (q == 0), combinational from q
shift_cnt  output  CNT_W  shift/rotate ops since last LOAD/CLR, saturating

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- While rst=1: q=RST_VAL and shift_cnt=0 immediately, independent of clk. zero follows q.
- Deassertion takes effect at the next rising edge.
- Priority: rst > en=0 > mode.
- Latency: every update lands one clk edge after the sampled inputs. Outputs derive only from registered state.
- en=0: q and shift_cnt hold for any mode value.
- Mode encoding (en=1):
  - 000 HOLD: q unchanged, cnt unchanged.
  - 001 LOAD: q<=d, cnt<=0.
  - 010 SHL: q<={q[W-2:0],sin_r}, cnt++.
  - 011 SHR: q<={sin_l,q[W-1:1]}, cnt++.
  - 100 ROL: q<={q[W-2:0],q[W-1]}, cnt++.
  - 101 ROR: q<={q[0],q[W-1:1]}, cnt++.
  - 110 ASR: q<={q[W-1],q[W-1:1]}, cnt++.
  - 111 CLR: q<=0 (not RST_VAL), cnt<=0.
- Counter: cnt++ saturates at 2^CNT_W-1 and never wraps. Only LOAD, CLR and rst clear it.
- WIDTH=1:
  - SHL gives q<=sin_r; SHR gives q<=sin_l.
  - ROL, ROR and ASR leave q unchanged but still increment cnt.
- sin_l and sin_r are sampled only in SHR and SHL respectively; ignored in all other modes.
- Reset mid-operation: an in-flight mode change is discarded. The first post-reset edge applies whatever mode is then presented.
- No X propagation: all mode codes are defined, so there is no illegal state.

Decomposition:
- Shared package usr_pkg:
  - 3-bit mode localparams MODE_HOLD … MODE_CLR.
  - A typedef for the mode field, reused by controllers driving the block.
- One natural sub-module: usr_next_val.
  - Purely combinational.
  - Computes next q and a cnt_inc/cnt_clr pair from q, d, mode, sin_l and sin_r.
- The top level holds the q/cnt flops, enable, reset and saturation logic.

Test Plan:
All scenarios use WIDTH=8, CNT_W=4, RST_VAL=8'h00.
1. Async reset: LOAD 8'hFF, then assert rst midway between edges -> q=00, zero=1, cnt=0 before the next edge; q holds 00 while rst=1.
2. LOAD/SHL: LOAD d=A5 -> q=A5, cnt=0. SHL sin_r=1 -> q=4B, cnt=1, sout_l=0, sout_r=1.
3. Rotate: LOAD 81. ROR -> C0. ROR -> 60 (cnt=2). ROL -> C0 (cnt=3).
4. ASR/SHR: LOAD 80. ASR x3 -> C0, E0, F0. Then LOAD 80 and SHR sin_l=0 -> 40. SHR with sin_l=1 from 40 -> A0.
5. Enable gating: q=3C, cnt=5. Hold en=0 for 4 cycles with mode cycling through LOAD (d=FF), CLR and SHL -> q=3C and cnt=5 throughout.
6. Saturation/CLR: LOAD 01, then 20 consecutive SHL (sin_r=0) -> cnt reaches 15 after the 15th and stays 15, q=00 from the 8th SHL on, zero=1. Then CLR -> q=00, cnt=0.
